// File: rtl/dmem_pkg.sv
// +--------------------------------------------------------------------+
// | dmem_pkg: shared defaults and FSM encoding for the dmem responder   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package dmem_pkg;

   localparam int DSIZE_DEF = 16;
   localparam int ISIZE_DEF = 16;

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_WAIT = 2'b01,
      S_RESP = 2'b10
   } state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_array.sv
// +--------------------------------------------------------------------+
// | dmem_array: word storage with synchronous write and sampled read    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_array #(
   parameter int DSIZE      = 16,
   parameter int DEPTH_LOG2 = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en,
   input  logic [DEPTH_LOG2-1:0] addr,
   input  logic [DSIZE-1:0]      wdata,
   input  logic                  rd_en,
   input  logic                  rd_zero,
   output logic [DSIZE-1:0]      rdata
);

   logic [DSIZE-1:0] mem [1<<DEPTH_LOG2];

   // Contents survive reset on purpose: only the read register is cleared.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[addr] <= wdata;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rdata <= '0;
      end else if (rd_en) begin
         rdata <= rd_zero ? '0 : mem[addr];
      end
   end

endmodule

`default_nettype wire

// File: rtl/dmem_responder.sv
// +--------------------------------------------------------------------+
// | dmem_responder: valid/ready memory responder with fixed wait states |
// | Option: DMEM_RESP_ERR_EN flags out-of-range addresses via rsp_err   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DSIZE      = DSIZE_DEF,
   parameter int ISIZE      = ISIZE_DEF,
   parameter int DEPTH_LOG2 = 8,
   parameter int WAIT       = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_wen,
   input  logic [ISIZE-1:0] req_addr,
   input  logic [DSIZE-1:0] req_wdata,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [DSIZE-1:0] rsp_rdata,
   output logic             rsp_wen,
   output logic             rsp_err,
   output logic             busy
);

   localparam logic [2:0] WAIT_LOAD = (WAIT == 0) ? 3'd0 : 3'(WAIT - 1);

   state_t           state;
   state_t           state_nx;
   logic [2:0]       cnt;
   logic             cap_wen;
   logic [ISIZE-1:0] cap_addr;
   logic [DSIZE-1:0] cap_wdata;

   logic             accept;
   logic             enter_resp;
   logic             op_wen;
   logic             op_err;
   logic [ISIZE-1:0] op_addr;
   logic [DSIZE-1:0] op_wdata;

   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      enter_resp = 1'b0;
      req_ready  = 1'b0;
      case (state)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept = 1'b1;
               if (WAIT == 0) begin
                  state_nx   = S_RESP;
                  enter_resp = 1'b1;
               end else begin
                  state_nx = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            if (cnt == 3'd0) begin
               state_nx   = S_RESP;
               enter_resp = 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               state_nx = S_IDLE;
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // With zero wait states RESP is entered on the accept edge itself, so the
   // operation must come straight from the request bus rather than the capture.
   assign op_wen   = (state == S_IDLE) ? req_wen   : cap_wen;
   assign op_addr  = (state == S_IDLE) ? req_addr  : cap_addr;
   assign op_wdata = (state == S_IDLE) ? req_wdata : cap_wdata;

`ifdef DMEM_RESP_ERR_EN
   assign op_err = |op_addr[ISIZE-1:DEPTH_LOG2];
`else
   logic unused_upper_addr;
   assign op_err            = 1'b0;
   assign unused_upper_addr = ^op_addr[ISIZE-1:DEPTH_LOG2];
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= 3'd0;
         cap_wen   <= 1'b0;
         cap_addr  <= '0;
         cap_wdata <= '0;
         rsp_wen   <= 1'b0;
         rsp_err   <= 1'b0;
      end else begin
         if (accept) begin
            cap_wen   <= req_wen;
            cap_addr  <= req_addr;
            cap_wdata <= req_wdata;
            cnt       <= WAIT_LOAD;
         end else if (state == S_WAIT && cnt != 3'd0) begin
            cnt <= cnt - 3'd1;
         end
         if (enter_resp) begin
            rsp_wen <= op_wen;
            rsp_err <= op_err;
         end
      end
   end

   dmem_array #(
      .DSIZE      (DSIZE),
      .DEPTH_LOG2 (DEPTH_LOG2)
   ) u_array (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (enter_resp & op_wen & ~op_err),
      .addr    (op_addr[DEPTH_LOG2-1:0]),
      .wdata   (op_wdata),
      .rd_en   (enter_resp),
      .rd_zero (op_wen | op_err),
      .rdata   (rsp_rdata)
   );

   assign rsp_valid = (state == S_RESP);
   assign busy      = (state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_dmem_responder.sv
// +--------------------------------------------------------------------+
// | tb_dmem_responder: three responders (WAIT=1,0,3) vs. reference model|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_dmem_responder;

`ifdef DMEM_RESP_ERR_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk;
   logic        rst       [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic        req_wen   [3];
   logic [15:0] req_addr  [3];
   logic [15:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [15:0] rsp_rdata [3];
   logic        rsp_wen   [3];
   logic        rsp_err   [3];
   logic        busy      [3];

   int          wt [3] = '{1, 0, 3};
   logic [15:0] mem_m [3][256];
   bit          known [3][256];
   int          checks = 0;
   int          failures = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   dmem_responder #(.WAIT(1)) u_w1 (
      .clk(clk), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_wen(req_wen[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_wen(rsp_wen[0]), .rsp_err(rsp_err[0]), .busy(busy[0]));

   dmem_responder #(.WAIT(0)) u_w0 (
      .clk(clk), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_wen(req_wen[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_wen(rsp_wen[1]), .rsp_err(rsp_err[1]), .busy(busy[1]));

   dmem_responder #(.WAIT(3)) u_w3 (
      .clk(clk), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_wen(req_wen[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_wen(rsp_wen[2]), .rsp_err(rsp_err[2]), .busy(busy[2]));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // One complete request/response, with latency and contents predicted from
   // the model. poke drives a competing store while the response is pending.
   task automatic do_txn(input int d, input bit wen, input logic [15:0] addr,
                         input logic [15:0] data, input int hold, input bit poke);
      int          idx;
      bit          err;
      bit          data_known;
      logic [15:0] exp_rd;
      idx        = int'(addr[7:0]);
      err        = ERR_EN && (addr[15:8] != 8'h00);
      data_known = wen || err || known[d][idx];
      exp_rd     = (wen || err) ? 16'h0000 : mem_m[d][idx];

      req_valid[d] = 1'b1;
      req_wen[d]   = wen;
      req_addr[d]  = addr;
      req_wdata[d] = data;
      chk("req_ready_idle", req_ready[d], 1);
      step();
      req_valid[d] = 1'b0;
      req_wdata[d] = 16'(~data);
      for (int k = 0; k < wt[d]; k++) begin
         chk("rsp_valid_early", rsp_valid[d], 0);
         chk("busy_wait", busy[d], 1);
         step();
      end
      chk("rsp_valid_latency", rsp_valid[d], 1);
      chk("req_ready_resp", req_ready[d], 0);
      if (data_known) chk("rsp_rdata", rsp_rdata[d], exp_rd);
      chk("rsp_wen", rsp_wen[d], wen);
      chk("rsp_err", rsp_err[d], err);
      if (wen && !err) begin
         mem_m[d][idx] = data;
         known[d][idx] = 1'b1;
      end

      rsp_ready[d] = 1'b0;
      if (poke) begin
         req_valid[d] = 1'b1;
         req_wen[d]   = 1'b1;
         req_addr[d]  = addr;
         req_wdata[d] = 16'hDEAD;
      end
      for (int h = 0; h < hold; h++) begin
         step();
         chk("hold_rsp_valid", rsp_valid[d], 1);
         chk("hold_req_ready", req_ready[d], 0);
         if (data_known) chk("hold_rsp_rdata", rsp_rdata[d], exp_rd);
         chk("hold_rsp_wen", rsp_wen[d], wen);
      end
      rsp_ready[d] = 1'b1;
      step();
      rsp_ready[d] = 1'b0;
      req_valid[d] = 1'b0;
      chk("post_rsp_valid", rsp_valid[d], 0);
      chk("post_busy", busy[d], 0);
      chk("post_req_ready", req_ready[d], 1);
   endtask

   initial begin
      logic [15:0] a;
      for (int d = 0; d < 3; d++) begin
         rst[d] = 1'b0; req_valid[d] = 1'b0; req_wen[d] = 1'b0;
         req_addr[d] = '0; req_wdata[d] = '0; rsp_ready[d] = 1'b0;
         for (int i = 0; i < 256; i++) known[d][i] = 1'b0;
      end
      repeat (3) step();
      for (int d = 0; d < 3; d++) rst[d] = 1'b1;
      step();
      for (int d = 0; d < 3; d++) begin
         chk("rst_req_ready", req_ready[d], 1);
         chk("rst_rsp_valid", rsp_valid[d], 0);
         chk("rst_busy", busy[d], 0);
         chk("rst_rsp_rdata", rsp_rdata[d], 0);
         chk("rst_rsp_wen", rsp_wen[d], 0);
         chk("rst_rsp_err", rsp_err[d], 0);
      end

      // WAIT=1: store then load, load held for 5 cycles with a competing store
      do_txn(0, 1'b1, 16'h0005, 16'hBEEF, 0, 1'b0);
      do_txn(0, 1'b0, 16'h0005, 16'h0000, 5, 1'b1);
      do_txn(0, 1'b0, 16'h0005, 16'h0000, 0, 1'b0);

      // top-index boundary
      do_txn(0, 1'b1, 16'h00FF, 16'hFFFF, 0, 1'b0);
      do_txn(0, 1'b0, 16'h00FF, 16'h0000, 1, 1'b0);

      // out-of-range store: dropped with error, or aliased onto index 5
      do_txn(0, 1'b1, 16'h0105, 16'h5A5A, 0, 1'b0);
      do_txn(0, 1'b0, 16'h0005, 16'h0000, 0, 1'b0);
      do_txn(0, 1'b0, 16'h0105, 16'h0000, 0, 1'b0);

      // WAIT=0: preload, then back-to-back loads with rsp_ready tied high
      for (int i = 0; i < 4; i++)
         do_txn(1, 1'b1, 16'(16'h0020 + i), 16'($urandom), 0, 1'b0);
      rsp_ready[1] = 1'b1;
      req_valid[1] = 1'b1;
      req_wen[1]   = 1'b0;
      req_addr[1]  = 16'h0020;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("b2b_rsp_valid", rsp_valid[1], 1);
         chk("b2b_req_ready", req_ready[1], 0);
         chk("b2b_rsp_rdata", rsp_rdata[1], mem_m[1][32 + i]);
         req_addr[1] = 16'(16'h0021 + i);
         step();
         chk("b2b_gap_valid", rsp_valid[1], 0);
         chk("b2b_gap_ready", req_ready[1], 1);
      end
      req_valid[1] = 1'b0;
      rsp_ready[1] = 1'b0;
      step();

      // WAIT=3: reset during the wait phase abandons the pending store
      do_txn(2, 1'b1, 16'h0010, 16'hAAAA, 0, 1'b0);
      req_valid[2] = 1'b1;
      req_wen[2]   = 1'b1;
      req_addr[2]  = 16'h0010;
      req_wdata[2] = 16'h1234;
      step();
      req_valid[2] = 1'b0;
      step();
      chk("pre_rst_busy", busy[2], 1);
      #2 rst[2] = 1'b0;
      #1;
      chk("async_rst_busy", busy[2], 0);
      chk("async_rst_rsp_valid", rsp_valid[2], 0);
      chk("async_rst_rsp_wen", rsp_wen[2], 0);
      chk("async_rst_rsp_rdata", rsp_rdata[2], 0);
      chk("async_rst_rsp_err", rsp_err[2], 0);
      chk("async_rst_req_ready", req_ready[2], 1);
      step();
      step();
      rst[2] = 1'b1;
      step();
      do_txn(2, 1'b0, 16'h0010, 16'h0000, 0, 1'b0);

      // randomized traffic on every instance
      for (int d = 0; d < 3; d++) begin
         for (int n = 0; n < 40; n++) begin
            a = 16'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) a[15:8] = 8'($urandom_range(1, 255));
            do_txn(d, 1'($urandom_range(0, 1)), a, 16'($urandom),
                   int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DSIZE, default 16, meaning data word width.
REQ-002 SHALL have parameter ISIZE, default 16, meaning request address width.
REQ-003 SHALL have parameter DEPTH_LOG2, default 8, meaning log2 of storage words (256).
REQ-004 SHALL have parameter WAIT, default 1, legal 0..7, meaning wait cycles between accept and response.
REQ-005 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_valid  input  1  initiator presents a request.
REQ-008 SHALL have port req_ready  output  1  responder accepts a request this cycle.
REQ-009 SHALL have port req_wen  input  1  1 = store, 0 = load.
REQ-010 SHALL have port req_addr  input  ISIZE  word address.
REQ-011 SHALL have port req_wdata  input  DSIZE  store data.
REQ-012 SHALL have port rsp_valid  output  1  response available.
REQ-013 SHALL have port rsp_ready  input  1  initiator consumes response.
REQ-014 SHALL have port rsp_rdata  output  DSIZE  load data; 0 for stores.
REQ-015 SHALL have port rsp_wen  output  1  echo of accepted req_wen.
REQ-016 SHALL have port rsp_err  output  1  address-range error (see Configuration).
REQ-017 SHALL have port busy  output  1  high whenever the FSM is not IDLE.

Function
REQ-018 SHALL implement the FSM states IDLE, WAIT, RESP.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on a rising edge with req_valid&req_ready.
REQ-020 SHALL, on accept, capture req_wen, req_addr and req_wdata, then go to WAIT with a counter loaded to WAIT-1, or go directly to RESP when WAIT=0.
REQ-021 SHALL, in WAIT, decrement the counter each cycle and go to RESP on the edge where the counter is 0.
REQ-022 SHALL perform the store write and sample the load data on the edge that enters RESP, giving rsp_valid WAIT+1 cycles after the accept edge.
REQ-023 SHALL, in RESP, hold rsp_valid=1 and keep rsp_rdata/rsp_wen/rsp_err stable until rsp_ready=1, then return to IDLE on that edge.
REQ-024 SHALL NOT allow a new accept in the cycle of the RESP handshake; the earliest next accept is the following cycle (one outstanding request max).
REQ-025 SHALL ignore req_* inputs while not in IDLE; no state change or write results from them.
REQ-026 SHALL index storage with req_addr[DEPTH_LOG2-1:0].
REQ-027 SHALL make a load return the most recent completed store to the same index.

Reset
REQ-028 SHALL, on rst low, asynchronously force state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_wen=0, rsp_err=0, busy=0; req_ready=1 after rst deasserts.
REQ-029 SHALL abandon any in-flight request on a reset mid-operation; a pending store that has not reached RESP entry is not written.
REQ-030 SHALL NOT reset storage contents.

Configuration
REQ-031 SHALL, with DMEM_RESP_ERR_EN defined, set rsp_err=1 for requests where req_addr[ISIZE-1:DEPTH_LOG2]!=0, drop the store, and return rsp_rdata=0; the handshake and latency are unchanged.
REQ-032 SHALL, without DMEM_RESP_ERR_EN, tie rsp_err=0 and let upper address bits alias (wrap-around).

Structure
REQ-033 SHALL place DSIZE/ISIZE defaults and the FSM state encoding (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) in shared package dmem_pkg.
REQ-034 SHALL isolate storage in sub-module dmem_array (synchronous write, read sampled into a register at RESP entry); FSM and handshake stay in dmem_responder.

Verification
REQ-035 SHALL verify: WAIT=1, store addr 0x0005 data 0xBEEF -> rsp_valid 2 cycles after accept, rsp_wen=1, rsp_rdata=0; a following load addr 0x0005 -> rsp_rdata=0xBEEF.
REQ-036 SHALL verify: WAIT=0, back-to-back loads with rsp_ready tied 1 -> one response per 2 cycles, req_ready low in RESP.
REQ-037 SHALL verify: rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable, req_ready=0, and a new req_valid ignored.
REQ-038 SHALL verify: WAIT=3, rst pulsed low during WAIT of store 0x1234 to addr 0x0010 -> outputs reset immediately and a later load of 0x0010 does not return 0x1234.
REQ-039 SHALL verify: with DMEM_RESP_ERR_EN, store to 0x0105 -> rsp_err=1 and addr 0x0005 unchanged; without it, the same store writes 0x0005 and rsp_err=0.
REQ-040 SHALL verify: store 0xFFFF to addr 0x00FF, then load 0x00FF -> 0xFFFF (top-index boundary).
